instr_encoder: RTL and testbench

//  Streaming MIPS instruction encoder: accepts one symbolic instruction per handshake
//  (class select + register/immediate fields) and emits the packed 32-bit word with its

---
 rtl/instr_encoder_pkg.sv | 37 +++
 rtl/instr_encoder_if.sv | 25 ++
 rtl/instr_encoder_pack.sv | 48 ++++
 rtl/instr_encoder.sv | 115 +++++++++++
 tb/tb_instr_encoder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared opcode/func codes, symbolic instruction selects and FSM state type for the MIPS instruction encoder.
package instr_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [3:0] {
    SEL_ADDU = 4'd0,
    SEL_SUBU = 4'd1,
    SEL_ORI  = 4'd2,
    SEL_LUI  = 4'd3,
    SEL_LW   = 4'd4,
    SEL_SW   = 4'd5,
    SEL_BEQ  = 4'd6,
    SEL_J    = 4'd7,
    SEL_JAL  = 4'd8,
    SEL_JR   = 4'd9
  } sel_e;

  typedef enum logic {
    S_ACCEPT = 1'b0,
    S_NOP    = 1'b1
  } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Symbolic-instruction input and encoded-word output handshakes of the instruction encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_sel, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_sel, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: instruction select plus fields -> legal flag, control-transfer flag, 32-bit word.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic        is_ctrl,
  output logic [31:0] word
);

  // Fields an instruction does not use are driven as zero, never passed through.
  always_comb begin
    legal   = 1'b1;
    is_ctrl = 1'b0;
    word    = '0;
    case (sel)
      SEL_ADDU: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADDU};
      SEL_SUBU: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUBU};
      SEL_ORI:  word = {OP_ORI, rs, rt, imm};
      SEL_LUI:  word = {OP_LUI, 5'd0, rt, imm};
      SEL_LW:   word = {OP_LW, rs, rt, imm};
      SEL_SW:   word = {OP_SW, rs, rt, imm};
      SEL_BEQ: begin
        word    = {OP_BEQ, rs, rt, imm};
        is_ctrl = 1'b1;
      end
      SEL_J: begin
        word    = {OP_J, target};
        is_ctrl = 1'b1;
      end
      SEL_JAL: begin
        word    = {OP_JAL, target};
        is_ctrl = 1'b1;
      end
      SEL_JR: begin
        word    = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
        is_ctrl = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: one register output stage, word-address counter, err/wrapped flags.
// Optional build macro DELAY_SLOT_NOP_EN appends a NOP word after every control-transfer word.
//
// state    | meaning
// S_ACCEPT | taking symbolic instructions when the output register is free
// S_NOP    | control transfer just loaded; next free slot gets a NOP word
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus,
  output logic            err,
  output logic            wrapped
);

  state_e             state, state_nxt;
  logic [ADDR_W-1:0]  word_index;
  logic [31:0]        out_instr_q;
  logic               out_valid_q;
  logic               in_ready_c;
  logic               load;
  logic [31:0]        load_word;
  logic               pk_legal, pk_ctrl;
  logic [31:0]        pk_word;
  logic               accept, out_fire, slot_free;

  instr_pack u_pack (
    .sel     (bus.in_sel),
    .rs      (bus.in_rs),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .imm     (bus.in_imm),
    .target  (bus.in_target),
    .legal   (pk_legal),
    .is_ctrl (pk_ctrl),
    .word    (pk_word)
  );

  assign slot_free = !out_valid_q || bus.out_ready;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign accept    = bus.in_valid && in_ready_c;

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    load       = 1'b0;
    load_word  = NOP_WORD;
    case (state)
      S_ACCEPT: begin
        in_ready_c = slot_free;
        if (accept && pk_legal) begin
          load      = 1'b1;
          load_word = pk_word;
`ifdef DELAY_SLOT_NOP_EN
          if (pk_ctrl) state_nxt = S_NOP;
`endif
        end
      end
      S_NOP: begin
        if (slot_free) begin
          load      = 1'b1;
          load_word = NOP_WORD;
          state_nxt = S_ACCEPT;
        end
      end
      default: state_nxt = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_ACCEPT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_instr_q <= load_word;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_index <= '0;
      wrapped    <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= accept && !pk_legal;
      if (out_fire) begin
        word_index <= word_index + ADDR_W'(1);
        if (word_index == {ADDR_W{1'b1}}) wrapped <= 1'b1;
      end
    end
  end

  // Address follows the index, so it stays put while a word is held.
  assign bus.out_addr  = BASE_ADDR + {{(30-ADDR_W){1'b0}}, word_index, 2'b00};
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.in_ready  = in_ready_c;

  // pk_ctrl only matters when delay-slot NOPs are built in.
  logic unused_ok;
  assign unused_ok = pk_ctrl;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder (ADDR_W=2 so the index wrap is reachable quickly).
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic err, wrapped;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [31:0] got_i[$];
  logic [31:0] got_a[$];
  int          got_c[$];

  instr_encoder_if bus();

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(32'h0000_3000)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err     (err),
    .wrapped (wrapped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (reset && bus.out_valid && bus.out_ready) begin
      got_i.push_back(bus.out_instr);
      got_a.push_back(bus.out_addr);
      got_c.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [31:0] ei, input logic [31:0] ea);
    chk({tag, "_present"}, 32'(got_i.size() > idx), 32'd1);
    if (got_i.size() > idx) begin
      chk({tag, "_instr"}, got_i[idx], ei);
      chk({tag, "_addr"}, got_a[idx], ea);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_imm = '0; bus.in_target = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    got_i.delete(); got_a.delete(); got_c.delete();
  endtask

  task automatic send(input logic [3:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel = sel; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_imm = imm; bus.in_target = tgt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  initial begin
    // 1: reset state and single addu, latency one cycle
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_addr", bus.out_addr, 32'h0000_3000);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    @(negedge clk);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_instr", bus.out_instr, 32'h0022_1821);
    chk("t1_addr", bus.out_addr, 32'h0000_3000);

    // 2: ori then lui back-to-back, lui's driven rs must be dropped
    do_reset();
    send(4'd2, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0);
    send(4'd3, 5'd7, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    repeat (4) @(posedge clk); #1;
    chk("t2_count", got_i.size(), 32'd2);
    chk_word("t2_w0", 0, 32'h3401_1234, 32'h0000_3000);
    chk_word("t2_w1", 1, 32'h3C02_FFFF, 32'h0000_3004);
    if (got_c.size() == 2) chk("t2_consec", got_c[1] - got_c[0], 32'd1);

    // 3: beq then jal, with or without delay-slot NOPs
    do_reset();
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'd3, 26'h0);
    send(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C03);
    repeat (6) @(posedge clk); #1;
`ifdef DELAY_SLOT_NOP_EN
    chk("t3_count", got_i.size(), 32'd4);
    chk_word("t3_w0", 0, 32'h1022_0003, 32'h0000_3000);
    chk_word("t3_w1", 1, 32'h0000_0000, 32'h0000_3004);
    chk_word("t3_w2", 2, 32'h0C00_0C03, 32'h0000_3008);
    chk_word("t3_w3", 3, 32'h0000_0000, 32'h0000_300C);
`else
    chk("t3_count", got_i.size(), 32'd2);
    chk_word("t3_w0", 0, 32'h1022_0003, 32'h0000_3000);
    chk_word("t3_w1", 1, 32'h0C00_0C03, 32'h0000_3004);
`endif

    // 4: backpressure holds the word and blocks input
    do_reset();
    bus.out_ready = 1'b0;
    send(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
    bus.in_valid = 1'b1;
    bus.in_sel = 4'd1; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_rd = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_instr", bus.out_instr, 32'h0085_3021);
      chk("t4_hold_addr", bus.out_addr, 32'h0000_3000);
      chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    repeat (4) @(posedge clk); #1;
    chk("t4_count", got_i.size(), 32'd2);
    chk_word("t4_w0", 0, 32'h0085_3021, 32'h0000_3000);
    chk_word("t4_w1", 1, 32'h0022_1823, 32'h0000_3004);

    // 5: illegal select pulses err and leaves the index alone
    do_reset();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(4'd12, 5'd9, 5'd9, 5'd9, 16'hABCD, 26'h0);
    @(negedge clk);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_no_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("t5_err_pulse", 32'(err), 32'd0);
    @(posedge clk); #1;
    send(4'd2, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'h0);
    @(negedge clk);
    chk("t5_next_instr", bus.out_instr, 32'h3464_00FF);
    chk("t5_next_addr", bus.out_addr, 32'h0000_3004);
    chk("t5_count", got_i.size(), 32'd1);

    // 6: wrap with 4-word memory, then async reset with a word held
    do_reset();
    for (int i = 0; i < 5; i++) send(4'd7, 5'd0, 5'd0, 5'd0, 16'h0, 26'(i + 1));
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_instr", bus.out_instr, 32'h0800_0005);
    chk("t6_addr", bus.out_addr, 32'h0000_3000);
    chk("t6_wrapped", 32'(wrapped), 32'd1);
    chk_word("t6_w3", 3, 32'h0800_0004, 32'h0000_300C);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_addr", bus.out_addr, 32'h0000_3000);
    chk("t6_rst_wrapped", 32'(wrapped), 32'd0);
    chk("t6_rst_instr", bus.out_instr, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
